// File: rtl/median_window_filter.sv
// 3x3 median filter: sort-network pipeline writing one median per window to the output RAM.
// Optional BORDER_ZERO_EN: after the last median, zero-fill the image border before done.
module median_window_filter #(
  parameter int unsigned IMG_W  = 100,
  parameter int unsigned IMG_H  = 100,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned ADDR_W = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9*PIX_W-1:0] win_bus,
  input  logic               win_valid,
  output logic               out_we,
  output logic [ADDR_W-1:0]  out_addr,
  output logic [PIX_W-1:0]   out_data,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  win_count
);
  localparam int unsigned N_WIN = (IMG_W - 2) * (IMG_H - 2);
  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam logic [ADDR_W-1:0] N_WIN_A  = ADDR_W'(N_WIN);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_W - 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
`ifdef BORDER_ZERO_EN
    BORDER = 2'd3,
`endif
    DONE   = 2'd2
  } state_t;

  function automatic logic [PIX_W-1:0] min2(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [PIX_W-1:0] max2(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    return (a < b) ? b : a;
  endfunction

  function automatic logic [PIX_W-1:0] med3(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b,
                                            input logic [PIX_W-1:0] c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  state_t            state_q, state_d;
  logic              accept_c;
  logic              busy_nx_c;
  logic              done_nx_c;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  logic [ADDR_W-1:0] tag_c;
  logic [ADDR_W-1:0] wr_count;

  logic              s1_valid, s2_valid, s3_valid;
  logic [PIX_W-1:0]  s1_pix [9];
  logic [ADDR_W-1:0] s1_tag, s2_tag, s3_tag;
  logic [PIX_W-1:0]  s2_lo [3];
  logic [PIX_W-1:0]  s2_md [3];
  logic [PIX_W-1:0]  s2_hi [3];
  logic [PIX_W-1:0]  s3_maxlo, s3_midmd, s3_minhi;

`ifdef BORDER_ZERO_EN
  localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] B_BOT    = ADDR_W'(2 * IMG_W);
  localparam logic [ADDR_W-1:0] B_LEFT   = ADDR_W'(2 * IMG_W + IMG_H - 2);
  localparam logic [ADDR_W-1:0] N_BDR    = ADDR_W'(2 * IMG_W + 2 * (IMG_H - 2));
  localparam logic [ADDR_W-1:0] BOT_BASE = ADDR_W'((IMG_H - 1) * IMG_W);

  logic [ADDR_W-1:0] bidx_q;
  logic [ADDR_W-1:0] bdr_addr_c;
  logic              bdr_we_c;

  // Border order: top row, bottom row, left column, right column.
  always_comb begin
    bdr_addr_c = bidx_q;
    if (bidx_q < W_A) begin
      bdr_addr_c = bidx_q;
    end else if (bidx_q < B_BOT) begin
      bdr_addr_c = BOT_BASE + bidx_q - W_A;
    end else if (bidx_q < B_LEFT) begin
      bdr_addr_c = (bidx_q - B_BOT + ADDR_W'(1)) * W_A;
    end else begin
      bdr_addr_c = (bidx_q - B_LEFT + ADDR_W'(1)) * W_A + W_A - ADDR_W'(1);
    end
  end
`endif

  assign tag_c = ADDR_W'(row_q) * ADDR_W'(IMG_W) + ADDR_W'(col_q);

  // Next-state and acceptance decode.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
`ifdef BORDER_ZERO_EN
    bdr_we_c = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (win_valid && (win_count < N_WIN_A)) begin
          accept_c = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        accept_c = win_valid && (win_count < N_WIN_A);
        if (out_we && (wr_count == N_WIN_A)) begin
`ifdef BORDER_ZERO_EN
          state_d = BORDER;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef BORDER_ZERO_EN
      BORDER: begin
        bdr_we_c = (bidx_q < N_BDR);
        if (out_we && (bidx_q == N_BDR)) begin
          state_d = DONE;
        end
      end
`endif
      default: ;
    endcase
`ifdef BORDER_ZERO_EN
    busy_nx_c = (state_d == RUN) || (state_d == BORDER);
`else
    busy_nx_c = (state_d == RUN);
`endif
    done_nx_c = (state_d == DONE);
  end

  // Sort-network datapath; qualified by the valid chain below, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      for (int i = 0; i < 9; i++) begin
        s1_pix[i] <= win_bus[(8 - i) * PIX_W +: PIX_W];
      end
      s1_tag <= tag_c;
    end
    for (int r = 0; r < 3; r++) begin
      s2_lo[r] <= min2(min2(s1_pix[3*r], s1_pix[3*r+1]), s1_pix[3*r+2]);
      s2_md[r] <= med3(s1_pix[3*r], s1_pix[3*r+1], s1_pix[3*r+2]);
      s2_hi[r] <= max2(max2(s1_pix[3*r], s1_pix[3*r+1]), s1_pix[3*r+2]);
    end
    s2_tag   <= s1_tag;
    s3_maxlo <= max2(max2(s2_lo[0], s2_lo[1]), s2_lo[2]);
    s3_midmd <= med3(s2_md[0], s2_md[1], s2_md[2]);
    s3_minhi <= min2(min2(s2_hi[0], s2_hi[1]), s2_hi[2]);
    s3_tag   <= s2_tag;
  end

  // Control state, counters, valid chain and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      win_count <= '0;
      wr_count  <= '0;
      row_q     <= ROW_W'(1);
      col_q     <= COL_W'(1);
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      out_we    <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
`ifdef BORDER_ZERO_EN
      bidx_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      busy     <= busy_nx_c;
      done     <= done_nx_c;
      s1_valid <= accept_c;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
      out_we   <= s3_valid;
      if (accept_c) begin
        win_count <= win_count + ADDR_W'(1);
        if (col_q == COL_LAST) begin
          col_q <= COL_W'(1);
          row_q <= row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
      if (s3_valid) begin
        out_addr <= s3_tag;
        out_data <= med3(s3_maxlo, s3_midmd, s3_minhi);
        wr_count <= wr_count + ADDR_W'(1);
      end
`ifdef BORDER_ZERO_EN
      if (bdr_we_c) begin
        out_we   <= 1'b1;
        out_addr <= bdr_addr_c;
        out_data <= '0;
        bidx_q   <= bidx_q + ADDR_W'(1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_median_window_filter.sv
// Bench for median_window_filter: random windows checked every cycle against a sort-based median model.
module tb_median_window_filter;
  localparam int W    = 100;
  localparam int H    = 100;
  localparam int NWIN = (W - 2) * (H - 2);
`ifdef BORDER_ZERO_EN
  localparam int NBDR = 2 * W + 2 * (H - 2);
`else
  localparam int NBDR = 0;
`endif
  localparam int TOTAL_W = NWIN + NBDR;

  typedef struct {
    int cyc;
    int addr;
    int data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [71:0] win_bus = '0;
  logic        win_valid = 1'b0;
  logic        out_we;
  logic [13:0] out_addr;
  logic [7:0]  out_data;
  logic        busy;
  logic        done;
  logic [13:0] win_count;

  median_window_filter #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .ADDR_W(14)) dut (
    .clk(clk), .rst(rst), .win_bus(win_bus), .win_valid(win_valid),
    .out_we(out_we), .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done), .win_count(win_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Driver-owned literal pins: the next write after arming must match these.
  int pin_id = 0;
  int pin_addr = 0;
  int pin_data = 0;
  logic finish_req = 1'b0;

  // Checker-owned model state.
  int   checks = 0;
  int   errors = 0;
  int   acc = 0;
  int   n_writes = 0;
  int   last_addr = 0;
  int   last_data = 0;
  int   pin_done = 0;
  logic rst_prev = 1'b1;
  logic done_x, busy_x;
  exp_t e;
  exp_t exp_q[$];

  function automatic int median9(input logic [71:0] w);
    int a[9];
    int t;
    for (int i = 0; i < 9; i++) a[i] = int'(w[(8 - i) * 8 +: 8]);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    return a[4];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Compare outputs of this cycle, then fold this cycle's inputs into the model.
  always @(negedge clk) begin
    if (rst_prev) begin
      chk("rst_we", out_we, 0);
      chk("rst_addr", out_addr, 0);
      chk("rst_data", out_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_win_count", win_count, 0);
      last_addr = 0;
      last_data = 0;
    end else begin
      done_x = (n_writes == TOTAL_W);
      busy_x = (acc > 0) && !done_x;
      chk("done", done, done_x);
      chk("busy", busy, busy_x);
      chk("win_count", win_count, acc);
      if (out_we) begin
        if (exp_q.size() == 0) begin
          chk("spurious_we", out_we, 0);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc >= 0) chk("we_cycle", cyc, e.cyc);
          chk("addr", out_addr, e.addr);
          chk("data", out_data, e.data);
          n_writes++;
          last_addr = e.addr;
          last_data = e.data;
          if (pin_id != pin_done) begin
            chk("pin_addr", out_addr, pin_addr);
            chk("pin_data", out_data, pin_data);
            pin_done = pin_id;
          end
        end
      end else begin
        chk("hold_addr", out_addr, last_addr);
        chk("hold_data", out_data, last_data);
        if (exp_q.size() > 0 && exp_q[0].cyc >= 0 && cyc >= exp_q[0].cyc) begin
          chk("missing_we", out_we, 1);
          void'(exp_q.pop_front());
        end
      end
    end

    if (rst) begin
      exp_q.delete();
      acc = 0;
      n_writes = 0;
    end else if (win_valid && acc < NWIN) begin
      e.cyc  = cyc + 4;
      e.addr = (1 + acc / (W - 2)) * W + 1 + acc % (W - 2);
      e.data = median9(win_bus);
      exp_q.push_back(e);
      acc++;
`ifdef BORDER_ZERO_EN
      if (acc == NWIN) begin
        e.cyc = -1;
        e.data = 0;
        for (int c = 0; c < W; c++) begin e.addr = c; exp_q.push_back(e); end
        for (int c = 0; c < W; c++) begin e.addr = (H - 1) * W + c; exp_q.push_back(e); end
        for (int r = 1; r < H - 1; r++) begin e.addr = r * W; exp_q.push_back(e); end
        for (int r = 1; r < H - 1; r++) begin e.addr = r * W + W - 1; exp_q.push_back(e); end
      end
`endif
    end
    rst_prev = rst;

    if (finish_req || cyc > 95000) begin
      chk("drain", exp_q.size(), 0);
      if (!finish_req) begin
        errors++;
        $display("FAIL timeout: got cycle %0d, want finish before 95000", cyc);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  task automatic step(input logic v, input logic [71:0] d);
    @(posedge clk);
    #1;
    win_valid = v;
    win_bus = d;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0);
  endtask

  task automatic arm(input int a, input int v);
    pin_addr = a;
    pin_data = v;
    pin_id++;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst = 1'b1;
    win_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Random window; about a third use a narrow value range to force ties.
  function automatic logic [71:0] rand_win();
    logic [71:0] w;
    logic        narrow;
    narrow = ($urandom_range(0, 2) == 0);
    for (int i = 0; i < 9; i++) begin
      w[i*8 +: 8] = narrow ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
    end
    return w;
  endfunction

  initial begin
    int gap;
    int budget;
    logic [71:0] d;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Single window, then impulse patterns.
    arm(101, 5);
    step(1'b1, 72'h09_01_08_02_07_03_06_04_05);
    idle(8);
    arm(102, 0);
    step(1'b1, 72'h00_00_00_00_FF_00_00_00_00);
    idle(8);
    arm(103, 255);
    step(1'b1, 72'hFF_00_FF_00_FF_00_FF_00_FF);
    idle(8);
    arm(104, 85);
    step(1'b1, {9{8'h55}});
    idle(8);

    // Back-to-back windows from a fresh reset.
    do_reset(2);
    arm(101, 48);
    step(1'b1, {9{8'h30}});
    step(1'b1, rand_win());
    step(1'b1, rand_win());
    idle(8);

    // Reset two cycles after a window discards it.
    step(1'b1, rand_win());
    step(1'b0, '0);
    do_reset(1);
    idle(2);

    // Full image stream.
    for (int k = 0; k < NWIN; k++) begin
      d = rand_win();
      gap = (k < 300 || k >= NWIN - 100) ? 9 : int'($urandom_range(1, 3));
      case (k)
        0:        begin d = {9{8'h10}}; arm(101, 16); end
        97:       begin d = {9{8'h11}}; arm(198, 17); end
        98:       begin d = {9{8'h22}}; arm(201, 34); end
        NWIN - 1: begin d = {9{8'h33}}; arm(9898, 51); end
        default: ;
      endcase
      step(1'b1, d);
      idle(gap - 1);
    end

    // One window beyond the image must be ignored.
    step(1'b1, rand_win());
    step(1'b0, '0);
    budget = 0;
    while (budget < 2000 && !done) begin
      step(1'b0, '0);
      budget++;
    end
    idle(10);
    finish_req = 1'b1;
    repeat (5) @(posedge clk);
  end

endmodule
